// File: rtl/rti_operand_loader_pkg.sv
// Shared RTI definitions: FSM state encoding, canonical quiet NaN and default
// operand-completeness mask, common to the operand loader and intersection engine.
package rti_operand_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } rti_state_t;

  localparam logic [31:0] RTI_QNAN             = 32'h7FC0_0000;
  localparam logic [15:0] RTI_DEFAULT_REQ_MASK = 16'h7FFF;

  function automatic int rti_addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rti_operand_loader_if.sv
// CPU-side bus of the RTI operand loader: operand writes, launch request and
// the held response channel.
interface rti_operand_loader_if #(
  parameter int NUM_FPRTI_REGS = 16
) ();
  import rti_operand_loader_pkg::*;

  localparam int AW = rti_addr_bits(NUM_FPRTI_REGS);

  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [31:0]   wr_data_i;
  logic          wr_ready_o;
  logic          start_i;
  logic          busy_o;
  logic [31:0]   rsp_data_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_err_o;

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, start_i, rsp_ready_i,
    output wr_ready_o, busy_o, rsp_data_o, rsp_valid_o, rsp_err_o
  );

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, start_i, rsp_ready_i,
    input  wr_ready_o, busy_o, rsp_data_o, rsp_valid_o, rsp_err_o
  );

endinterface

// File: rtl/rti_operand_loader_rf.sv
// Operand register file with per-register written tracking; addresses beyond
// NUM_FPRTI_REGS match no entry and are dropped.
module rti_operand_rf
  import rti_operand_loader_pkg::*;
#(
  parameter int NUM_FPRTI_REGS = 16,
  parameter int AW             = rti_addr_bits(NUM_FPRTI_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [31:0]               wr_data,
  input  logic                      clr_written,
  output logic [31:0]               regs [NUM_FPRTI_REGS],
  output logic [NUM_FPRTI_REGS-1:0] written,
  output logic [NUM_FPRTI_REGS-1:0] wr_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FPRTI_REGS; gi++) begin : g_entry
      logic [31:0] data_reg;
      logic        written_reg;

      assign wr_onehot[gi] = wr_en && (wr_addr == AW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg    <= '0;
          written_reg <= 1'b0;
        end else begin
          if (wr_onehot[gi]) begin
            data_reg <= wr_data;
          end
          // clear and write never coincide: writes happen only in IDLE
          if (clr_written) begin
            written_reg <= 1'b0;
          end else if (wr_onehot[gi]) begin
            written_reg <= 1'b1;
          end
        end
      end

      assign regs[gi]    = data_reg;
      assign written[gi] = written_reg;
    end
  endgenerate

endmodule

// File: rtl/rti_operand_loader.sv
// RTI operand loader: collects operands, launches the intersection engine and
// returns its result. Optional WAIT watchdog enabled by macro RTI_TIMEOUT_EN.
module rti_operand_loader
  import rti_operand_loader_pkg::*;
#(
  parameter int                        NUM_FPRTI_REGS = 16,
  parameter logic [NUM_FPRTI_REGS-1:0] REQ_MASK       = RTI_DEFAULT_REQ_MASK,
  parameter int                        TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  rti_operand_loader_if.slave cpu,
  output logic [31:0] fprti_regs_o [NUM_FPRTI_REGS],
  output logic        input_valid_o,
  input  logic [31:0] engine_result_i,
  input  logic        engine_valid_i
);

  localparam int AW = rti_addr_bits(NUM_FPRTI_REGS);

  rti_state_t                state_reg;
  logic                      wr_ready_reg;
  logic                      busy_reg;
  logic                      input_valid_reg;
  logic                      rsp_valid_reg;
  logic                      rsp_err_reg;
  logic [31:0]               rsp_data_reg;
  logic [NUM_FPRTI_REGS-1:0] written;
  logic [NUM_FPRTI_REGS-1:0] wr_onehot;
  logic                      wr_accept;
  logic                      clr_written;
  logic                      operands_ok;

  assign wr_accept   = cpu.wr_en_i && wr_ready_reg;
  assign clr_written = (state_reg == ST_RESP) && cpu.rsp_ready_i;
  // a write landing in the same cycle as start counts toward completeness
  assign operands_ok = (((written | wr_onehot) & REQ_MASK) == REQ_MASK);

  rti_operand_rf #(
    .NUM_FPRTI_REGS (NUM_FPRTI_REGS),
    .AW             (AW)
  ) u_rf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_accept),
    .wr_addr     (cpu.wr_addr_i),
    .wr_data     (cpu.wr_data_i),
    .clr_written (clr_written),
    .regs        (fprti_regs_o),
    .written     (written),
    .wr_onehot   (wr_onehot)
  );

`ifdef RTI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      wr_ready_reg    <= 1'b1;
      busy_reg        <= 1'b0;
      input_valid_reg <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_data_reg    <= '0;
`ifdef RTI_TIMEOUT_EN
      cnt_reg         <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cpu.start_i) begin
            wr_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (operands_ok) begin
              state_reg       <= ST_ISSUE;
              input_valid_reg <= 1'b1;
            end else begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_data_reg  <= '0;
            end
          end
        end
        ST_ISSUE: begin
          input_valid_reg <= 1'b0;
          state_reg       <= ST_WAIT;
`ifdef RTI_TIMEOUT_EN
          cnt_reg         <= '0;
`endif
        end
        ST_WAIT: begin
          if (engine_valid_i) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= engine_result_i;
          end
`ifdef RTI_TIMEOUT_EN
          else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b1;
            rsp_data_reg  <= RTI_QNAN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (cpu.rsp_ready_i) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            wr_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu.wr_ready_o  = wr_ready_reg;
  assign cpu.busy_o      = busy_reg;
  assign cpu.rsp_valid_o = rsp_valid_reg;
  assign cpu.rsp_err_o   = rsp_err_reg;
  assign cpu.rsp_data_o  = rsp_data_reg;
  assign input_valid_o   = input_valid_reg;

endmodule

// File: tb/tb_rti_operand_loader.sv
// Directed self-checking bench for rti_operand_loader; the watchdog steps run
// only when RTI_TIMEOUT_EN is defined.
module tb_rti_operand_loader;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fprti_regs [N];
  logic        input_valid;
  logic [31:0] engine_result = '0;
  logic        engine_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  rti_operand_loader_if #(.NUM_FPRTI_REGS(N)) cpu_if ();

  rti_operand_loader #(
    .NUM_FPRTI_REGS (N),
    .REQ_MASK       (16'h7FFF),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu             (cpu_if.slave),
    .fprti_regs_o    (fprti_regs),
    .input_valid_o   (input_valid),
    .engine_result_i (engine_result),
    .engine_valid_i  (engine_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input int addr, input logic [31:0] data);
    cpu_if.wr_en_i   = 1'b1;
    cpu_if.wr_addr_i = 4'(addr);
    cpu_if.wr_data_i = data;
    tick();
    cpu_if.wr_en_i   = 1'b0;
  endtask

  task automatic accept();
    cpu_if.rsp_ready_i = 1'b1;
    tick();
    cpu_if.rsp_ready_i = 1'b0;
    check("accept_rsp_valid", {31'd0, cpu_if.rsp_valid_o}, 32'd0);
    check("accept_wr_ready", {31'd0, cpu_if.wr_ready_o}, 32'd1);
  endtask

  initial begin
    cpu_if.wr_en_i     = 1'b0;
    cpu_if.wr_addr_i   = '0;
    cpu_if.wr_data_i   = '0;
    cpu_if.start_i     = 1'b0;
    cpu_if.rsp_ready_i = 1'b0;
    #12;
    check("rst_wr_ready", {31'd0, cpu_if.wr_ready_o}, 32'd1);
    check("rst_busy", {31'd0, cpu_if.busy_o}, 32'd0);
    check("rst_input_valid", {31'd0, input_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, cpu_if.rsp_valid_o}, 32'd0);
    check("rst_reg5", fprti_regs[5], 32'd0);
    rst_n = 1'b1;
    tick();

    // full launch: regs 0..14 written, engine answers 1.0
    for (int i = 0; i < 15; i++) write_reg(i, 32'h1000_0000 + i);
    check("wr_reg14", fprti_regs[14], 32'h1000_000E);
    cpu_if.start_i = 1'b1;
    tick();
    cpu_if.start_i = 1'b0;
    check("launch_input_valid", {31'd0, input_valid}, 32'd1);
    check("launch_busy", {31'd0, cpu_if.busy_o}, 32'd1);
    check("launch_wr_ready", {31'd0, cpu_if.wr_ready_o}, 32'd0);
    tick();
    check("wait_input_valid", {31'd0, input_valid}, 32'd0);
    engine_valid  = 1'b1;
    engine_result = 32'h3F80_0000;
    tick();
    engine_valid  = 1'b0;
    engine_result = 32'h0;
    check("ok_rsp_valid", {31'd0, cpu_if.rsp_valid_o}, 32'd1);
    check("ok_rsp_data", cpu_if.rsp_data_o, 32'h3F80_0000);
    check("ok_rsp_err", {31'd0, cpu_if.rsp_err_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rsp_valid", {31'd0, cpu_if.rsp_valid_o}, 32'd1);
      check("hold_rsp_data", cpu_if.rsp_data_o, 32'h3F80_0000);
    end
    accept();

    // written bits cleared by accept: start without rewriting must fail
    cpu_if.start_i = 1'b1;
    tick();
    cpu_if.start_i = 1'b0;
    check("norewrite_input_valid", {31'd0, input_valid}, 32'd0);
    check("norewrite_rsp_valid", {31'd0, cpu_if.rsp_valid_o}, 32'd1);
    check("norewrite_rsp_err", {31'd0, cpu_if.rsp_err_o}, 32'd1);
    check("norewrite_rsp_data", cpu_if.rsp_data_o, 32'd0);
    accept();

    // incomplete operands: regs 0..13 only
    for (int i = 0; i < 14; i++) write_reg(i, 32'h2000_0000 + i);
    cpu_if.start_i = 1'b1;
    tick();
    cpu_if.start_i = 1'b0;
    check("partial_input_valid", {31'd0, input_valid}, 32'd0);
    check("partial_rsp_err", {31'd0, cpu_if.rsp_err_o}, 32'd1);
    check("partial_rsp_data", cpu_if.rsp_data_o, 32'd0);
    accept();

    // reg 14 written in the same cycle as start completes the set
    for (int i = 0; i < 14; i++) write_reg(i, 32'h3000_0000 + i);
    cpu_if.wr_en_i   = 1'b1;
    cpu_if.wr_addr_i = 4'd14;
    cpu_if.wr_data_i = 32'h3000_000E;
    cpu_if.start_i   = 1'b1;
    tick();
    cpu_if.wr_en_i   = 1'b0;
    cpu_if.start_i   = 1'b0;
    check("samecycle_input_valid", {31'd0, input_valid}, 32'd1);
    check("samecycle_reg14", fprti_regs[14], 32'h3000_000E);
    tick();

    // in WAIT: writes and start are ignored
    cpu_if.wr_en_i   = 1'b1;
    cpu_if.wr_addr_i = 4'd3;
    cpu_if.wr_data_i = 32'hDEAD_BEEF;
    cpu_if.start_i   = 1'b1;
    tick();
    check("wait_wr_ready", {31'd0, cpu_if.wr_ready_o}, 32'd0);
    check("wait_reg3", fprti_regs[3], 32'h3000_0003);
    check("wait_no_relaunch", {31'd0, input_valid}, 32'd0);
    tick();
    cpu_if.wr_en_i = 1'b0;
    cpu_if.start_i = 1'b0;
    check("wait_no_relaunch2", {31'd0, input_valid}, 32'd0);
    check("wait_busy", {31'd0, cpu_if.busy_o}, 32'd1);
    check("wait_reg3_b", fprti_regs[3], 32'h3000_0003);
    engine_valid  = 1'b1;
    engine_result = 32'h4049_0FDB;
    tick();
    engine_valid  = 1'b0;
    check("pi_rsp_data", cpu_if.rsp_data_o, 32'h4049_0FDB);
    check("pi_rsp_err", {31'd0, cpu_if.rsp_err_o}, 32'd0);
    accept();

    // engine strobe while IDLE is ignored
    engine_valid = 1'b1;
    tick();
    engine_valid = 1'b0;
    check("idle_engine_rsp_valid", {31'd0, cpu_if.rsp_valid_o}, 32'd0);
    check("idle_engine_busy", {31'd0, cpu_if.busy_o}, 32'd0);

`ifdef RTI_TIMEOUT_EN
    for (int i = 0; i < 15; i++) write_reg(i, 32'h5000_0000 + i);
    cpu_if.start_i = 1'b1;
    tick();
    cpu_if.start_i = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_not_yet", {31'd0, cpu_if.rsp_valid_o}, 32'd0);
    end
    tick();
    check("to_rsp_valid", {31'd0, cpu_if.rsp_valid_o}, 32'd1);
    check("to_rsp_err", {31'd0, cpu_if.rsp_err_o}, 32'd1);
    check("to_rsp_data", cpu_if.rsp_data_o, 32'h7FC0_0000);
    accept();
`endif

    // asynchronous reset in the middle of WAIT
    for (int i = 0; i < 15; i++) write_reg(i, 32'h6000_0000 + i);
    cpu_if.start_i = 1'b1;
    tick();
    cpu_if.start_i = 1'b0;
    tick();
    check("pre_rst_busy", {31'd0, cpu_if.busy_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, cpu_if.busy_o}, 32'd0);
    check("midrst_wr_ready", {31'd0, cpu_if.wr_ready_o}, 32'd1);
    check("midrst_reg0", fprti_regs[0], 32'd0);
    check("midrst_rsp_data", cpu_if.rsp_data_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_busy", {31'd0, cpu_if.busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rti_operand_loader.md
RTI_OPERAND_LOADER -- requirements
Module: rti_operand_loader

Interface
REQ-001 Parameter NUM_FPRTI_REGS, default 16, number of 32-bit operand registers presented to the intersection engine.
REQ-002 Parameter REQ_MASK, default 16'h7FFF, registers that must be written before a launch is accepted (P0,P1,P2,R0,Rd = regs 0..14).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit in WAIT (used only when RTI_TIMEOUT_EN is defined).
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port wr_en_i  input  1  CPU operand write strobe.
REQ-007 Port wr_addr_i  input  $clog2(NUM_FPRTI_REGS)  operand register index.
REQ-008 Port wr_data_i  input  32  FP32 operand bits.
REQ-009 Port wr_ready_o  output  1  high only in IDLE; writes accepted when wr_en_i & wr_ready_o.
REQ-010 Port start_i  input  1  launch request pulse.
REQ-011 Port busy_o  output  1  high in every state except IDLE.
REQ-012 Port fprti_regs_o  output  [NUM_FPRTI_REGS] x 32  operand array to engine, driven continuously from the register file.
REQ-013 Port input_valid_o  output  1  one-cycle launch pulse to engine.
REQ-014 Port engine_result_i  input  32  engine return value.
REQ-015 Port engine_valid_i  input  1  engine result strobe.
REQ-016 Port rsp_data_o  output  32  captured result to CPU.
REQ-017 Port rsp_valid_o  output  1  response valid; held until accepted.
REQ-018 Port rsp_ready_i  input  1  CPU accepts response.
REQ-019 Port rsp_err_o  output  1  response is an error (incomplete operands or timeout); valid with rsp_valid_o.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: accepted write stores wr_data_i into reg[wr_addr_i] and sets written[wr_addr_i]; wr_addr_i >= NUM_FPRTI_REGS ignored, no bit set.
REQ-022 IDLE + start_i: if (written | same-cycle write bit) covers REQ_MASK -> ISSUE; else -> RESP with rsp_err_o=1, rsp_data_o=0.
REQ-023 ISSUE: input_valid_o=1 for exactly one cycle, then -> WAIT; latency start_i (cycle 0) to input_valid_o (cycle 1).
REQ-024 WAIT: engine_valid_i captures engine_result_i into rsp_data_o, rsp_err_o=0, -> RESP; rsp_valid_o asserts the following cycle.
REQ-025 RESP: rsp_valid_o=1 while in RESP; rsp_valid_o & rsp_ready_i -> IDLE, clear all written bits; data/err stable until accepted.
REQ-026 start_i outside IDLE, wr_en_i outside IDLE, engine_valid_i outside WAIT SHALL be ignored with no state change.
REQ-027 Operand registers SHALL NOT change outside IDLE, so fprti_regs_o is stable for the whole operation.

Reset
REQ-028 rst_n low at any time, including mid-operation, SHALL asynchronously force IDLE and clear all registers, written bits, counter, rsp_data_o, rsp_err_o; outputs: wr_ready_o=1, busy_o=0, input_valid_o=0, rsp_valid_o=0, fprti_regs_o all 0.

Configuration
REQ-029 Macro RTI_TIMEOUT_EN defined: counter cleared on ISSUE, increments each WAIT cycle; on reaching TIMEOUT_CYCLES without engine_valid_i -> RESP with rsp_err_o=1, rsp_data_o=32'h7FC00000; engine_valid_i in the same cycle wins.
REQ-030 Macro undefined: no counter logic; WAIT exits only on engine_valid_i.

Structure
REQ-031 FSM state enum, NaN constant 32'h7FC00000 and default REQ_MASK SHALL live in a shared rti package used by both this block and the intersection engine.
REQ-032 Operand register file with written-bit tracking SHALL be one sub-module, rti_operand_rf; FSM, response and watchdog stay in the top.

Verification
REQ-033 Write regs 0..14, start at cycle 0 -> input_valid_o=1 only at cycle 1; engine_valid_i with 32'h3F800000 -> rsp_valid_o next cycle, rsp_data_o=32'h3F800000, rsp_err_o=0.
REQ-034 Write regs 0..13 only, start -> no input_valid_o; rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0.
REQ-035 Write reg 14 in the same cycle as start with 0..13 already written -> launch accepted, input_valid_o next cycle.
REQ-036 During WAIT write reg 3=32'hDEADBEEF and pulse start_i -> wr_ready_o=0, fprti_regs_o[3] unchanged, no second input_valid_o.
REQ-037 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and rsp_data_o stable; after accept, a start without rewriting gives an error response (written bits cleared).
REQ-038 With RTI_TIMEOUT_EN and TIMEOUT_CYCLES=8, no engine_valid_i -> after 8 WAIT cycles rsp_err_o=1, rsp_data_o=32'h7FC00000; rst_n low in WAIT -> IDLE immediately, busy_o=0.
